// File: rtl/mem_access.sv
// mem_access: load/store stage between execute and writeback.
// One access at a time over a req/gnt/rvalid data-memory port.
module mem_access #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] mem_data,
  output logic        load_done,
  output logic        misalign,
  output logic        timeout_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [1:0]    r_size;
  logic          r_uns;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [31:0]   r_mem_data;
  logic          r_misalign;
  logic          r_tmo;

  logic          w_align;
  logic          w_legal;
  logic          w_illegal;
  logic          w_accept;
  logic          w_tmo;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic [31:0]   w_sh;
  logic [31:0]   w_ld;

  // Alignment check for the incoming command
  always_comb begin
    w_align = 1'b0;
    unique case (mem_size)
      2'b00:   w_align = 1'b1;
      2'b01:   w_align = ~addr[0];
      2'b10:   w_align = (addr[1:0] == 2'b00);
      default: w_align = 1'b0;
    endcase
  end

  assign w_legal   = (mem_rd ^ mem_wr) & w_align;
  assign w_illegal = (mem_rd | mem_wr) & ~w_legal;
  assign w_accept  = (r_state == S_IDLE) & w_legal;
  assign w_tmo     = (r_cnt == CW'(TIMEOUT - 1));

  // Byte enables and lane-replicated store data
  always_comb begin
    w_be = 4'b1111;
    w_wd = wdata;
    unique case (mem_size)
      2'b00: begin
        w_be = 4'b0001 << addr[1:0];
        w_wd = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be = addr[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{wdata[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = wdata;
      end
    endcase
  end

  // Lane select and extension of returned load data
  assign w_sh = dmem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ld = dmem_rdata;
    unique case (r_size)
      2'b00: w_ld = r_uns ? {24'h0, w_sh[7:0]}
                          : {{24{w_sh[7]}}, w_sh[7:0]};
      2'b01: w_ld = r_uns ? {16'h0, w_sh[15:0]}
                          : {{16{w_sh[15]}}, w_sh[15:0]};
      default: w_ld = dmem_rdata;
    endcase
  end

  // Access FSM, timeout counter and registered response pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_size     <= '0;
      r_uns      <= 1'b0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_mem_data <= '0;
      r_misalign <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      r_tmo      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt      <= '0;
          r_misalign <= w_illegal;
          if (w_accept) begin
            r_addr  <= addr;
            r_size  <= mem_size;
            r_uns   <= mem_unsigned;
            r_we    <= mem_wr;
            r_wdata <= w_wd;
            r_be    <= w_be;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + CW'(1);
          if (dmem_gnt) begin
            r_state <= r_we ? S_RESP : S_WAIT;
          end else if (w_tmo) begin
            r_state    <= S_RESP;
            r_tmo      <= 1'b1;
            r_mem_data <= '0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (dmem_rvalid) begin
            r_mem_data <= w_ld;
            r_state    <= S_RESP;
          end else if (w_tmo) begin
            r_state    <= S_RESP;
            r_tmo      <= 1'b1;
            r_mem_data <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall = rst_n & (w_accept | (r_state == S_REQ) |
                          (r_state == S_WAIT));
  assign dmem_req    = rst_n & (r_state == S_REQ);
  assign dmem_we     = r_we;
  assign dmem_addr   = {r_addr[31:2], 2'b00};
  assign dmem_be     = r_be;
  assign dmem_wdata  = r_wdata;
  assign mem_data    = r_mem_data;
  assign load_done   = (r_state == S_RESP) & ~r_we;
  assign misalign    = r_misalign;
  assign timeout_err = r_tmo;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed checks of the mem_access load/store stage.
// Memory handshake is driven step by step from one initial block.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] mem_data;
  logic        load_done;
  logic        misalign;
  logic        timeout_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .mem_size(mem_size),
    .mem_unsigned(mem_unsigned),
    .addr(addr),
    .wdata(wdata),
    .stall(stall),
    .mem_data(mem_data),
    .load_done(load_done),
    .misalign(misalign),
    .timeout_err(timeout_err),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] rd,
                         input logic [31:0] exp);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    mem_rd = 1'b1; mem_wr = 1'b0; mem_size = sz;
    mem_unsigned = uns; addr = a; wdata = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    chk("ld_c0_stall", stall, 1);
    chk("ld_c0_req", dmem_req, 0);
    tick();
    dmem_gnt = 1'b1;
    #1;
    chk("ld_c1_req", dmem_req, 1);
    chk("ld_c1_we", dmem_we, 0);
    chk("ld_c1_addr", dmem_addr, wa);
    chk("ld_c1_stall", stall, 1);
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rd;
    #1;
    chk("ld_c2_stall", stall, 1);
    chk("ld_c2_req", dmem_req, 0);
    chk("ld_c2_done", load_done, 0);
    tick();
    dmem_rvalid = 1'b0;
    #1;
    chk("ld_c3_data", mem_data, exp);
    chk("ld_c3_done", load_done, 1);
    chk("ld_c3_stall", stall, 0);
    chk("ld_c3_tmo", timeout_err, 0);
    tick();
    mem_rd = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] wd, input int dly,
                          input logic [3:0] ebe,
                          input logic [31:0] ewd);
    mem_rd = 1'b0; mem_wr = 1'b1; mem_size = sz;
    mem_unsigned = 1'b0; addr = a; wdata = wd;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    chk("st_c0_stall", stall, 1);
    for (int i = 0; i <= dly; i++) begin
      tick();
      dmem_gnt = (i == dly);
      #1;
      chk("st_req", dmem_req, 1);
      chk("st_we", dmem_we, 1);
      chk("st_be", dmem_be, ebe);
      chk("st_wdata", dmem_wdata, ewd);
      chk("st_addr", dmem_addr, {a[31:2], 2'b00});
      chk("st_stall", stall, 1);
    end
    tick();
    dmem_gnt = 1'b0;
    #1;
    chk("st_resp_stall", stall, 0);
    chk("st_resp_done", load_done, 0);
    chk("st_resp_req", dmem_req, 0);
    tick();
    mem_wr = 1'b0;
  endtask

  logic [31:0] bad_addr [4];
  logic [1:0]  bad_size [4];
  logic        bad_wr   [4];

  initial begin
    rst_n = 1'b0;
    mem_rd = 1'b1; mem_wr = 1'b0; mem_size = 2'b10;
    mem_unsigned = 1'b0; addr = 32'h0; wdata = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    tick();
    tick();
    chk("rst_stall", stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_done", load_done, 0);
    chk("rst_mis", misalign, 0);
    chk("rst_tmo", timeout_err, 0);
    rst_n = 1'b1; mem_rd = 1'b0;
    tick();

    do_load(32'h100, 2'b10, 1'b0, 32'h8899AABB, 32'h8899AABB);
    do_load(32'h103, 2'b00, 1'b0, 32'h80112233, 32'hFFFFFF80);
    do_load(32'h103, 2'b00, 1'b1, 32'h80112233, 32'h00000080);
    do_load(32'h102, 2'b01, 1'b0, 32'hF00D1234, 32'hFFFFF00D);
    do_load(32'h101, 2'b00, 1'b1, 32'h80112233, 32'h00000022);
    do_load(32'h100, 2'b01, 1'b0, 32'hF00D1234, 32'h00001234);

    do_store(32'h0A2, 2'b01, 32'hABCD1234, 3, 4'b1100, 32'h12341234);
    chk("st_keep_data", mem_data, 32'h00001234);
    do_store(32'h001, 2'b00, 32'h0000005A, 0, 4'b0010, 32'h5A5A5A5A);
    do_store(32'h010, 2'b10, 32'hCAFEF00D, 1, 4'b1111, 32'hCAFEF00D);

    bad_addr[0] = 32'h101; bad_size[0] = 2'b10; bad_wr[0] = 1'b0;
    bad_addr[1] = 32'h003; bad_size[1] = 2'b01; bad_wr[1] = 1'b0;
    bad_addr[2] = 32'h000; bad_size[2] = 2'b11; bad_wr[2] = 1'b0;
    bad_addr[3] = 32'h100; bad_size[3] = 2'b10; bad_wr[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_rd = 1'b1; mem_wr = bad_wr[k];
      mem_size = bad_size[k]; addr = bad_addr[k];
      #1;
      chk("mis_stall", stall, 0);
      chk("mis_req0", dmem_req, 0);
      chk("mis_pre", misalign, 0);
      tick();
      mem_rd = 1'b0; mem_wr = 1'b0;
      #1;
      chk("mis_pulse", misalign, 1);
      chk("mis_req1", dmem_req, 0);
      tick();
      chk("mis_clear", misalign, 0);
    end

    mem_rd = 1'b1; mem_wr = 1'b0; mem_size = 2'b10;
    mem_unsigned = 1'b0; addr = 32'h300;
    #1;
    chk("to_c0_stall", stall, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("to_req", dmem_req, 1);
      chk("to_tmo_low", timeout_err, 0);
    end
    tick();
    chk("to_req_drop", dmem_req, 0);
    chk("to_err", timeout_err, 1);
    chk("to_data", mem_data, 0);
    chk("to_done", load_done, 1);
    chk("to_stall", stall, 0);
    tick();
    mem_rd = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555;
    #1;
    chk("to_err_clear", timeout_err, 0);
    tick();
    dmem_rvalid = 1'b0;
    chk("to_stray_data", mem_data, 0);
    chk("to_stray_done", load_done, 0);
    chk("to_stray_stall", stall, 0);

    do_load(32'h104, 2'b10, 1'b0, 32'h12345678, 32'h12345678);

    mem_rd = 1'b1; mem_wr = 1'b0; mem_size = 2'b10; addr = 32'h200;
    #1;
    tick();
    dmem_gnt = 1'b1;
    #1;
    chk("rw_req", dmem_req, 1);
    tick();
    dmem_gnt = 1'b0; rst_n = 1'b0;
    #1;
    chk("rw_stall_forced", stall, 0);
    chk("rw_req_forced", dmem_req, 0);
    tick();
    rst_n = 1'b1; mem_rd = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("rw_stall", stall, 0);
    chk("rw_req", dmem_req, 0);
    chk("rw_done", load_done, 0);
    chk("rw_data", mem_data, 0);
    chk("rw_tmo", timeout_err, 0);
    chk("rw_mis", misalign, 0);
    chk("rw_addr", dmem_addr, 0);
    chk("rw_be", dmem_be, 0);
    tick();
    dmem_rvalid = 1'b0;
    chk("rw_stray_data", mem_data, 0);
    chk("rw_stray_done", load_done, 0);

    do_load(32'h208, 2'b10, 1'b0, 32'hA5A5F00F, 32'hA5A5F00F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Load/store stage placed between `execute` and `writeback`. It takes the ALU result as the memory address and `read2data` as store data, and runs one access at a time on a variable-latency data-memory port using a req/gnt/rvalid handshake. Load data is aligned and extended, then driven to the writeback `mem_data` input. The stage stalls the upstream pipeline for the whole access.

## Interface
- `TIMEOUT`, default 64: cycles allowed in REQ+WAIT before the access is aborted (≥2).
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low).
- `mem_rd`  in  1  current instruction is a load.
- `mem_wr`  in  1  current instruction is a store.
- `mem_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `mem_unsigned`  in  1  zero-extend loads (else sign-extend).
- `addr`  in  32  byte address (execute `result`).
- `wdata`  in  32  store data (`read2data`).
- `stall`  out  1  hold upstream stages and instruction.
- `mem_data`  out  32  extended load data to writeback.
- `load_done`  out  1  `mem_data` valid (RESP cycle of a load).
- `misalign`  out  1  one-cycle error pulse: bad alignment/size/both-commands.
- `timeout_err`  out  1  one-cycle pulse: access aborted.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  word address ({addr[31:2],2'b00}).
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_gnt`  in  1  request accepted.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE
  - Legal request: exactly one of `mem_rd`/`mem_wr` set, size ≠ 11, aligned (half: addr[0]=0; word: addr[1:0]=0).
  - Legal request: capture addr/size/unsigned/we/wdata/be into registers; `stall`=1 combinationally; next state REQ.
  - Illegal request: no access, `stall`=0, `misalign`=1 in the next cycle, stay IDLE.
  - No command: idle.
- REQ: `dmem_req`=1 with registered fields, held stable until `dmem_gnt`. On gnt, a store goes to RESP and a load goes to WAIT.
- WAIT: on `dmem_rvalid`, select the lane by addr[1:0] (byte) or addr[1] (half), extend per `mem_unsigned`, register into `mem_data`; next state RESP.
- RESP: `stall`=0, `load_done`=1 for loads. Pipeline advances at the end of this cycle. Next state IDLE.
- Byte enables and store data:
  - byte: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - word: be = 1111.
- `dmem_be` is driven for loads too; memory ignores it on reads.
- Timeout:
  - Counter clears in IDLE and increments each cycle in REQ/WAIT.
  - On the cycle count = TIMEOUT−1 without gnt/rvalid: go to RESP, `timeout_err`=1, `mem_data`=0, `load_done`=1 for loads, `dmem_req` drops.
- `dmem_rvalid` outside WAIT is ignored.
- `mem_data` holds its last value outside RESP.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, counter 0, `mem_data`=0, `misalign`/`timeout_err`/`load_done`=0. While `rst_n`=0, `stall` and `dmem_req` are forced to 0.
- Reset mid-access aborts with no response pulse. A later stray rvalid is ignored.
- `stall`=1 in the IDLE-accept cycle, REQ and WAIT. Otherwise 0.
- Minimum load is 4 cycles: accept, REQ+gnt, WAIT+rvalid, RESP.
- Minimum store is 3 cycles: accept, REQ+gnt, RESP.
- rvalid is never taken in the gnt cycle.
- Each extra cycle before gnt or rvalid adds one cycle.
- Back-to-back accesses: the next instruction is accepted in the IDLE cycle after RESP, giving 1 dead-free turnaround cycle.

## Test plan
- Word load, addr 0x100, gnt in the 1st REQ cycle, rvalid the next cycle with 0x8899AABB -> `mem_data`=0x8899AABB and `load_done`=1 in cycle 3; `stall` high in cycles 0–2.
- Signed byte load at addr 0x103, rdata 0x80112233 -> 0xFFFFFF80. The same with `mem_unsigned`=1 -> 0x00000080. Half at 0x102 signed, rdata 0xF00D1234 -> 0xFFFFF00D.
- Half store 0xABCD1234 at 0x0A2, gnt delayed 3 cycles -> `dmem_be`=1100, `dmem_wdata`=0x12341234, `dmem_we`=1 held for 4 REQ cycles; RESP 1 cycle later with `load_done`=0.
- Word load at 0x101, half at 0x003, size 11, and `mem_rd`=`mem_wr`=1 -> no `dmem_req`, `stall`=0, `misalign` pulse the next cycle for each.
- TIMEOUT=8 with gnt withheld -> `dmem_req` for 8 cycles, then RESP with `timeout_err`=1, `mem_data`=0, `load_done`=1. A later rvalid has no effect.
- `rst_n` low for 1 cycle during WAIT -> IDLE next cycle, all outputs 0. The next load completes normally.
